// File: rtl/key_schedule_pkg.sv
// key_schedule_pkg: shared definitions for the PRESENT key-schedule engine.
//   ROT_AMT          key register rotation per round (left on the forward path).
//   RK_WIDTH         width of an emitted round key.
//   CNT_LSB_80/_128  LSB of the 5-bit round-counter XOR field for each key width.
//   state_e          engine FSM states.
//   cnt_field_lsb()  counter-field LSB for a given key width.
//   present_sbox()   4-bit PRESENT S-box.
//   update_80/128()  one forward key-register update for each key width.
package key_schedule_pkg;

  localparam int ROT_AMT     = 61;
  localparam int RK_WIDTH    = 64;
  localparam int CNT_LSB_80  = 15;
  localparam int CNT_LSB_128 = 62;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic int cnt_field_lsb(input int key_width);
    return (key_width == 128) ? CNT_LSB_128 : CNT_LSB_80;
  endfunction

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hc;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hb;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'ha;  4'h7: y = 4'hd;
      4'h8: y = 4'h3;  4'h9: y = 4'he;  4'ha: y = 4'hf;  4'hb: y = 4'h8;
      4'hc: y = 4'h4;  4'hd: y = 4'h7;  4'he: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [79:0] update_80(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r = (k << ROT_AMT) | (k >> (80 - ROT_AMT));
    r[79:76] = present_sbox(r[79:76]);
    r[CNT_LSB_80 +: 5] = r[CNT_LSB_80 +: 5] ^ i;
    return r;
  endfunction

  function automatic logic [127:0] update_128(input logic [127:0] k, input logic [4:0] i);
    logic [127:0] r;
    r = (k << ROT_AMT) | (k >> (128 - ROT_AMT));
    r[127:124] = present_sbox(r[127:124]);
    r[123:120] = present_sbox(r[123:120]);
    r[CNT_LSB_128 +: 5] = r[CNT_LSB_128 +: 5] ^ i;
    return r;
  endfunction

endpackage

// File: rtl/key_schedule_seq_sbox_inv.sv
// sbox_inv: 4-bit inverse PRESENT S-box (purely combinational).
// Only present when KEY_SCHEDULE_INVERSE_EN is defined, the only build that uses it.
//   nib_in  [3:0] substituted nibble
//   nib_out [3:0] original nibble
`ifdef KEY_SCHEDULE_INVERSE_EN
module sbox_inv (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  always_comb begin
    nib_out = 4'h0;
    case (nib_in)
      4'h0: nib_out = 4'h5;  4'h1: nib_out = 4'he;  4'h2: nib_out = 4'hf;  4'h3: nib_out = 4'h8;
      4'h4: nib_out = 4'hc;  4'h5: nib_out = 4'h1;  4'h6: nib_out = 4'h2;  4'h7: nib_out = 4'hd;
      4'h8: nib_out = 4'hb;  4'h9: nib_out = 4'h4;  4'ha: nib_out = 4'h6;  4'hb: nib_out = 4'h3;
      4'hc: nib_out = 4'h0;  4'hd: nib_out = 4'h7;  4'he: nib_out = 4'h9;  default: nib_out = 4'ha;
    endcase
  end

endmodule
`endif

// File: rtl/sbox.sv
// sbox: 4-bit PRESENT S-box (purely combinational).
//   nib_in  [3:0] input nibble
//   nib_out [3:0] substituted nibble
module sbox (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  always_comb begin
    nib_out = 4'h0;
    case (nib_in)
      4'h0: nib_out = 4'hc;  4'h1: nib_out = 4'h5;  4'h2: nib_out = 4'h6;  4'h3: nib_out = 4'hb;
      4'h4: nib_out = 4'h9;  4'h5: nib_out = 4'h0;  4'h6: nib_out = 4'ha;  4'h7: nib_out = 4'hd;
      4'h8: nib_out = 4'h3;  4'h9: nib_out = 4'he;  4'ha: nib_out = 4'hf;  4'hb: nib_out = 4'h8;
      4'hc: nib_out = 4'h4;  4'hd: nib_out = 4'h7;  4'he: nib_out = 4'h1;  default: nib_out = 4'h2;
    endcase
  end

endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential PRESENT key schedule. Takes an 80/128-bit master
// key and streams round keys K1..K(ROUNDS+1), one per accepted handshake.
// Optional macro KEY_SCHEDULE_INVERSE_EN adds load_inv: the loaded key is then the
// post-final-update register and keys stream in reverse (K(ROUNDS+1)..K1).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   load_valid/load_ready   master-key handshake, key_in (and load_inv) sampled on it
//   rk_valid/rk_ready       round-key handshake
//   rk, rk_index, rk_last   current round key, its index, last-of-sequence flag
//
// Handshake rule (both interfaces): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds valid and payload stable until
// the transfer; ready may change freely and the engine never waits on its own ready.
module key_schedule_seq
  import key_schedule_pkg::*;
#(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [KEY_WIDTH-1:0] key_in,
`ifdef KEY_SCHEDULE_INVERSE_EN
  input  logic                 load_inv,
`endif
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [RK_WIDTH-1:0]  rk,
  output logic [5:0]           rk_index,
  output logic                 rk_last
);

  localparam int         CNT_LSB  = cnt_field_lsb(KEY_WIDTH);
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS + 1);

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_width
    $error("key_schedule_seq: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("key_schedule_seq: ROUNDS must be in 1..31");
  end

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [5:0]           idx_q, idx_d;
  logic                 last_q, last_d;
  logic                 load_ready_q, load_ready_d;
  logic                 rk_valid_q, rk_valid_d;

  // Forward update: rotate, S-box the top nibble(s), XOR the round index.
  logic [KEY_WIDTH-1:0] fwd_rot, fwd_key;
  logic [3:0]           fwd_sb_hi, fwd_sb_lo;

  assign fwd_rot = (key_q << ROT_AMT) | (key_q >> (KEY_WIDTH - ROT_AMT));

  sbox u_sbox_hi (.nib_in(fwd_rot[KEY_WIDTH-1 -: 4]), .nib_out(fwd_sb_hi));
  if (KEY_WIDTH == 128) begin : g_sbox_lo
    sbox u_sbox_lo (.nib_in(fwd_rot[KEY_WIDTH-5 -: 4]), .nib_out(fwd_sb_lo));
  end else begin : g_no_sbox_lo
    // 80-bit keys substitute only the top nibble; the next one passes through.
    assign fwd_sb_lo = fwd_rot[KEY_WIDTH-5 -: 4];
  end

  always_comb begin
    fwd_key                   = fwd_rot;
    fwd_key[KEY_WIDTH-1 -: 4] = fwd_sb_hi;
    fwd_key[KEY_WIDTH-5 -: 4] = fwd_sb_lo;
    fwd_key[CNT_LSB +: 5]     = fwd_rot[CNT_LSB +: 5] ^ idx_q[4:0];
  end

`ifdef KEY_SCHEDULE_INVERSE_EN
  // Inverse update undoes the forward steps in reverse order using the index of
  // the key being stepped back to (rk_index-1). Low 5 bits of idx_q minus one
  // equal that index even at idx_q=32.
  logic                 inv_q, inv_d;
  logic [4:0]           inv_i;
  logic [KEY_WIDTH-1:0] inv_x, inv_sub, inv_key;
  logic [3:0]           inv_sb_hi, inv_sb_lo;

  assign inv_i = idx_q[4:0] - 5'd1;

  always_comb begin
    inv_x                 = key_q;
    inv_x[CNT_LSB +: 5]   = key_q[CNT_LSB +: 5] ^ inv_i;
  end

  sbox_inv u_sbox_inv_hi (.nib_in(inv_x[KEY_WIDTH-1 -: 4]), .nib_out(inv_sb_hi));
  if (KEY_WIDTH == 128) begin : g_sbox_inv_lo
    sbox_inv u_sbox_inv_lo (.nib_in(inv_x[KEY_WIDTH-5 -: 4]), .nib_out(inv_sb_lo));
  end else begin : g_no_sbox_inv_lo
    assign inv_sb_lo = inv_x[KEY_WIDTH-5 -: 4];
  end

  always_comb begin
    inv_sub                   = inv_x;
    inv_sub[KEY_WIDTH-1 -: 4] = inv_sb_hi;
    inv_sub[KEY_WIDTH-5 -: 4] = inv_sb_lo;
  end

  assign inv_key = (inv_sub >> ROT_AMT) | (inv_sub << (KEY_WIDTH - ROT_AMT));
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef KEY_SCHEDULE_INVERSE_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = RUN;
          key_d   = key_in;
          // ROUNDS >= 1, so the first key is never the last one.
          last_d  = 1'b0;
`ifdef KEY_SCHEDULE_INVERSE_EN
          inv_d   = load_inv;
          idx_d   = load_inv ? LAST_IDX : 6'd1;
`else
          idx_d   = 6'd1;
`endif
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
`ifdef KEY_SCHEDULE_INVERSE_EN
            if (inv_q) begin
              key_d  = inv_key;
              idx_d  = idx_q - 6'd1;
              last_d = (idx_q == 6'd2);
            end else begin
              key_d  = fwd_key;
              idx_d  = idx_q + 6'd1;
              last_d = ((idx_q + 6'd1) == LAST_IDX);
            end
`else
            key_d  = fwd_key;
            idx_d  = idx_q + 6'd1;
            last_d = ((idx_q + 6'd1) == LAST_IDX);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == IDLE);
    rk_valid_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      key_q        <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      load_ready_q <= 1'b1;
      rk_valid_q   <= 1'b0;
`ifdef KEY_SCHEDULE_INVERSE_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      load_ready_q <= load_ready_d;
      rk_valid_q   <= rk_valid_d;
`ifdef KEY_SCHEDULE_INVERSE_EN
      inv_q        <= inv_d;
`endif
    end
  end

  assign load_ready = load_ready_q;
  assign rk_valid   = rk_valid_q;
  assign rk         = key_q[KEY_WIDTH-1 -: RK_WIDTH];
  assign rk_index   = idx_q;
  assign rk_last    = last_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: directed bench for key_schedule_seq with one 80-bit and
// one 128-bit instance (ROUNDS=31). Inputs change #1 after a rising edge or on
// the falling edge; outputs are sampled on the falling edge.
module tb_key_schedule_seq;
  import key_schedule_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         lv80, lr80, rkv80, rkr80, rkl80;
  logic [79:0]  key80;
  logic [63:0]  rk80;
  logic [5:0]   idx80;
  logic         lv128, lr128, rkv128, rkr128, rkl128;
  logic [127:0] key128;
  logic [63:0]  rk128;
  logic [5:0]   idx128;
`ifdef KEY_SCHEDULE_INVERSE_EN
  logic         inv80, inv128;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0]  exp_q[$];
  logic [79:0]  final80;
  logic [127:0] final128;

  key_schedule_seq #(.KEY_WIDTH(80), .ROUNDS(31)) dut80 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv80), .load_ready(lr80), .key_in(key80),
`ifdef KEY_SCHEDULE_INVERSE_EN
    .load_inv(inv80),
`endif
    .rk_valid(rkv80), .rk_ready(rkr80), .rk(rk80), .rk_index(idx80), .rk_last(rkl80)
  );

  key_schedule_seq #(.KEY_WIDTH(128), .ROUNDS(31)) dut128 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv128), .load_ready(lr128), .key_in(key128),
`ifdef KEY_SCHEDULE_INVERSE_EN
    .load_inv(inv128),
`endif
    .rk_valid(rkv128), .rk_ready(rkr128), .rk(rk128), .rk_index(idx128), .rk_last(rkl128)
  );

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded its time budget, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- model / driver tasks ----------------
  task automatic fill_exp80(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_q.delete();
    for (int i = 1; i <= 32; i++) begin
      exp_q.push_back(k[79:16]);
      if (i < 32) k = update_80(k, 5'(i));
    end
    final80 = k;
  endtask

  task automatic fill_exp128(input logic [127:0] key);
    logic [127:0] k;
    k = key;
    exp_q.delete();
    for (int i = 1; i <= 32; i++) begin
      exp_q.push_back(k[127:64]);
      if (i < 32) k = update_128(k, 5'(i));
    end
    final128 = k;
  endtask

  task automatic load80(input logic [79:0] key);
    @(posedge clk); #1;
    key80 = key;
    lv80  = 1'b1;
    @(posedge clk); #1;
    lv80  = 1'b0;
  endtask

  task automatic load128(input logic [127:0] key);
    @(posedge clk); #1;
    key128 = key;
    lv128  = 1'b1;
    @(posedge clk); #1;
    lv128  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (lr80 !== 1'b1)   begin bad++; $display("FAIL rst80_load_ready got=%b exp=1", lr80); end
    total++; if (rkv80 !== 1'b0)  begin bad++; $display("FAIL rst80_rk_valid got=%b exp=0", rkv80); end
    total++; if (rk80 !== 64'h0)  begin bad++; $display("FAIL rst80_rk got=%h exp=0", rk80); end
    total++; if (idx80 !== 6'd0)  begin bad++; $display("FAIL rst80_rk_index got=%0d exp=0", idx80); end
    total++; if (rkl80 !== 1'b0)  begin bad++; $display("FAIL rst80_rk_last got=%b exp=0", rkl80); end
    total++; if (lr128 !== 1'b1)  begin bad++; $display("FAIL rst128_load_ready got=%b exp=1", lr128); end
    total++; if (rkv128 !== 1'b0) begin bad++; $display("FAIL rst128_rk_valid got=%b exp=0", rkv128); end
    total++; if (rk128 !== 64'h0) begin bad++; $display("FAIL rst128_rk got=%h exp=0", rk128); end
    total++; if (idx128 !== 6'd0) begin bad++; $display("FAIL rst128_rk_index got=%0d exp=0", idx128); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (rkv80 !== 1'b0 || lr80 !== 1'b1) begin
      bad++; $display("FAIL post_rst_idle valid=%b ready=%b exp valid=0 ready=1", rkv80, lr80);
    end
  endtask

  task automatic run_fwd80(input logic [79:0] key, input string tag);
    logic [63:0] e;
    logic [63:0] hand [3];
    hand[0] = 64'h0000000000000000;
    hand[1] = 64'hc000000000000000;
    hand[2] = 64'h5000180000000001;
    fill_exp80(key);
    rkr80 = 1'b1;
    load80(key);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (rkv80 !== 1'b1) begin bad++; $display("FAIL %s_valid n=%0d got=%b exp=1", tag, n, rkv80); end
      total++; if (rk80 !== e)     begin bad++; $display("FAIL %s_rk n=%0d got=%h exp=%h", tag, n, rk80, e); end
      if (key == 80'h0 && n <= 3) begin
        total++; if (rk80 !== hand[n-1]) begin bad++; $display("FAIL %s_hand n=%0d got=%h exp=%h", tag, n, rk80, hand[n-1]); end
      end
      total++; if (idx80 !== 6'(n)) begin bad++; $display("FAIL %s_index got=%0d exp=%0d", tag, idx80, n); end
      total++; if (rkl80 !== (n == 32)) begin bad++; $display("FAIL %s_last n=%0d got=%b", tag, n, rkl80); end
      total++; if (lr80 !== 1'b0) begin bad++; $display("FAIL %s_load_ready_run n=%0d got=%b exp=0", tag, n, lr80); end
    end
    @(negedge clk);
    total++; if (lr80 !== 1'b1 || rkv80 !== 1'b0) begin
      bad++; $display("FAIL %s_done ready=%b valid=%b exp ready=1 valid=0", tag, lr80, rkv80);
    end
  endtask

  task automatic test_fwd80;
    run_fwd80(80'h0, "fwd80");
  endtask

  task automatic test_fwd128;
    logic [63:0] e;
    fill_exp128(128'h0);
    rkr128 = 1'b1;
    load128(128'h0);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (rkv128 !== 1'b1) begin bad++; $display("FAIL fwd128_valid n=%0d got=%b", n, rkv128); end
      total++; if (rk128 !== e) begin bad++; $display("FAIL fwd128_rk n=%0d got=%h exp=%h", n, rk128, e); end
      if (n == 1) begin
        total++; if (rk128 !== 64'h0) begin bad++; $display("FAIL fwd128_k1 got=%h exp=0", rk128); end
      end
      if (n == 2) begin
        total++; if (rk128 !== 64'hcc00000000000000) begin bad++; $display("FAIL fwd128_k2 got=%h exp=cc00000000000000", rk128); end
      end
      if (n == 32) begin
        total++; if (rk128 !== final128[127:64]) begin bad++; $display("FAIL fwd128_final got=%h exp=%h", rk128, final128[127:64]); end
      end
      total++; if (idx128 !== 6'(n)) begin bad++; $display("FAIL fwd128_index got=%0d exp=%0d", idx128, n); end
      total++; if (rkl128 !== (n == 32)) begin bad++; $display("FAIL fwd128_last n=%0d got=%b", n, rkl128); end
    end
    @(negedge clk);
    total++; if (lr128 !== 1'b1 || rkv128 !== 1'b0) begin
      bad++; $display("FAIL fwd128_done ready=%b valid=%b exp ready=1 valid=0", lr128, rkv128);
    end
  endtask

  task automatic test_back_to_back;
    run_fwd80(80'h0123456789abcdef0123, "b2b_a");
    run_fwd80(80'hfedcba9876543210fedc, "b2b_b");
  endtask

  task automatic test_backpressure;
    logic [63:0] e;
    fill_exp80(80'h0);
    rkr80 = 1'b1;
    load80(80'h0);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (rk80 !== e || idx80 !== 6'(n)) begin
        bad++; $display("FAIL bp_rk n=%0d got=%h/%0d exp=%h/%0d", n, rk80, idx80, e, n);
      end
      if (n == 3) begin
        rkr80 = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          total++; if (rk80 !== 64'h5000180000000001) begin bad++; $display("FAIL bp_hold_rk s=%0d got=%h exp=5000180000000001", s, rk80); end
          total++; if (rkv80 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid s=%0d got=%b exp=1", s, rkv80); end
          total++; if (idx80 !== 6'd3) begin bad++; $display("FAIL bp_hold_index s=%0d got=%0d exp=3", s, idx80); end
        end
        rkr80 = 1'b1;
      end
    end
    @(negedge clk);
    total++; if (lr80 !== 1'b1) begin bad++; $display("FAIL bp_done ready=%b exp=1", lr80); end
  endtask

  task automatic test_load_ignored;
    logic [63:0] e;
    fill_exp80(80'h0);
    rkr80 = 1'b1;
    load80(80'h0);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (rk80 !== e || idx80 !== 6'(n)) begin
        bad++; $display("FAIL ign_rk n=%0d got=%h/%0d exp=%h/%0d", n, rk80, idx80, e, n);
      end
      total++; if (lr80 !== 1'b0) begin bad++; $display("FAIL ign_load_ready n=%0d got=%b exp=0", n, lr80); end
      if (n == 5) begin
        key80 = 80'hffffffffffffffffffff;
        lv80  = 1'b1;
      end
      if (n == 8) lv80 = 1'b0;
    end
    @(negedge clk);
    total++; if (lr80 !== 1'b1 || rkv80 !== 1'b0) begin
      bad++; $display("FAIL ign_done ready=%b valid=%b exp ready=1 valid=0", lr80, rkv80);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] e;
    fill_exp80(80'h0);
    rkr80 = 1'b1;
    load80(80'h0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (rk80 !== e || idx80 !== 6'(n)) begin
        bad++; $display("FAIL rmid_rk n=%0d got=%h/%0d exp=%h/%0d", n, rk80, idx80, e, n);
      end
    end
    rst_n = 1'b0;
    #1;
    total++; if (rkv80 !== 1'b0)  begin bad++; $display("FAIL rmid_valid got=%b exp=0", rkv80); end
    total++; if (rk80 !== 64'h0)  begin bad++; $display("FAIL rmid_rk got=%h exp=0", rk80); end
    total++; if (lr80 !== 1'b1)   begin bad++; $display("FAIL rmid_load_ready got=%b exp=1", lr80); end
    total++; if (idx80 !== 6'd0)  begin bad++; $display("FAIL rmid_index got=%0d exp=0", idx80); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (rkv80 !== 1'b0) begin bad++; $display("FAIL rmid_no_output c=%0d got=%b exp=0", c, rkv80); end
    end
    run_fwd80(80'h0, "rmid_restart");
  endtask

`ifdef KEY_SCHEDULE_INVERSE_EN
  task automatic test_inverse;
    logic [63:0] e;
    fill_exp80(80'h0);
    rkr80 = 1'b1;
    inv80 = 1'b1;
    load80(final80);
    inv80 = 1'b0;
    for (int n = 32; n >= 1; n--) begin
      @(negedge clk);
      e = exp_q.pop_back();
      total++; if (rkv80 !== 1'b1) begin bad++; $display("FAIL inv80_valid n=%0d got=%b", n, rkv80); end
      total++; if (rk80 !== e) begin bad++; $display("FAIL inv80_rk n=%0d got=%h exp=%h", n, rk80, e); end
      total++; if (idx80 !== 6'(n)) begin bad++; $display("FAIL inv80_index got=%0d exp=%0d", idx80, n); end
      total++; if (rkl80 !== (n == 1)) begin bad++; $display("FAIL inv80_last n=%0d got=%b", n, rkl80); end
      if (n == 3) begin
        total++; if (rk80 !== 64'h5000180000000001) begin bad++; $display("FAIL inv80_k3 got=%h exp=5000180000000001", rk80); end
      end
      if (n == 1) begin
        total++; if (rk80 !== 64'h0) begin bad++; $display("FAIL inv80_k1 got=%h exp=0", rk80); end
      end
    end
    @(negedge clk);
    total++; if (lr80 !== 1'b1 || rkv80 !== 1'b0) begin
      bad++; $display("FAIL inv80_done ready=%b valid=%b", lr80, rkv80);
    end

    fill_exp128(128'h00112233445566778899aabbccddeeff);
    rkr128 = 1'b1;
    inv128 = 1'b1;
    load128(final128);
    inv128 = 1'b0;
    for (int n = 32; n >= 1; n--) begin
      @(negedge clk);
      e = exp_q.pop_back();
      total++; if (rk128 !== e || idx128 !== 6'(n)) begin
        bad++; $display("FAIL inv128_rk n=%0d got=%h/%0d exp=%h/%0d", n, rk128, idx128, e, n);
      end
      total++; if (rkl128 !== (n == 1)) begin bad++; $display("FAIL inv128_last n=%0d got=%b", n, rkl128); end
    end
    @(negedge clk);
    total++; if (lr128 !== 1'b1) begin bad++; $display("FAIL inv128_done ready=%b exp=1", lr128); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    lv80 = 1'b0; rkr80 = 1'b0; key80 = '0;
    lv128 = 1'b0; rkr128 = 1'b0; key128 = '0;
`ifdef KEY_SCHEDULE_INVERSE_EN
    inv80 = 1'b0; inv128 = 1'b0;
`endif
    test_reset();
    test_fwd80();
    test_fwd128();
    test_back_to_back();
    test_backpressure();
    test_load_ignored();
    test_reset_mid();
`ifdef KEY_SCHEDULE_INVERSE_EN
    test_inverse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
